// File: rtl/clock_controller_if.sv
// Bus bundle for clock_controller: control inputs from the host side and
// the generated CPU clock with its status strobes.
interface clock_controller_if #(
  parameter int DIV_W   = 24,
  parameter int BURST_W = 8
);
  logic [1:0]         mode;
  logic [DIV_W-1:0]   div;
  logic               step_btn;
  logic [BURST_W-1:0] burst_len;
  logic               halt;
  logic               cpu_clk;
  logic               rise_pulse;
  logic               burst_done;
  logic               halted;

  modport master (
    output mode, div, step_btn, burst_len, halt,
    input  cpu_clk, rise_pulse, burst_done, halted
  );

  modport slave (
    input  mode, div, step_btn, burst_len, halt,
    output cpu_clk, rise_pulse, burst_done, halted
  );
endinterface

// File: rtl/clock_controller.sv
// CPU clock generator: free-run, single-step and burst modes driven by a
// debounced step button, with a sticky halt that never truncates a high phase.
module clock_controller #(
  parameter int DIV_W           = 24,
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int BURST_W         = 8
) (
  input logic               clk,
  input logic               rst,
  clock_controller_if.slave bus
);

  localparam logic [1:0] ST_LOW  = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [1:0] MODE_FREE  = 2'd0;
  localparam logic [1:0] MODE_STEP  = 2'd1;
  localparam logic [1:0] MODE_BURST = 2'd2;

  localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Button synchronizer and debouncer
  logic            sync_1, sync_2;
  logic            db_level, db_prev;
  logic [DB_W-1:0] db_cnt;
  logic            step_req;

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values; blocking here would chain the synchronizer into one flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1   <= 1'b0;
      sync_2   <= 1'b0;
      db_level <= 1'b0;
      db_prev  <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sync_1  <= bus.step_btn;
      sync_2  <= sync_1;
      db_prev <= db_level;
      if (sync_2 != db_level) begin
        if (db_cnt == DB_LAST) begin
          db_level <= sync_2;
          db_cnt   <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign step_req = db_level & ~db_prev;

  // Clock FSM state
  logic [1:0]         state, state_n;
  logic [DIV_W-1:0]   phase_cnt, cnt_n;
  logic [DIV_W-1:0]   div_q, div_q_n;
  logic [BURST_W-1:0] steps_left, steps_n;
  logic [1:0]         mode_q, mode_q_n;
  logic               halt_pend, halt_pend_n;
  logic               enter_high, done_n;

  logic [1:0]         mode_eff;
  logic               mode_chg;
  logic [DIV_W-1:0]   lim;
  logic               phase_end;
  logic [BURST_W-1:0] steps_eff;
  logic [BURST_W-1:0] load_n;

  always_comb begin
    unique case (bus.mode)
      2'd0:    mode_eff = MODE_FREE;
      2'd2:    mode_eff = MODE_BURST;
      default: mode_eff = MODE_STEP;
    endcase
  end

  // The first cycle of a phase compares against live div; later cycles use the copy taken then.
  assign lim       = (phase_cnt == '0) ? bus.div : div_q;
  assign phase_end = (phase_cnt == lim);
  assign mode_chg  = (mode_eff != mode_q);
  assign steps_eff = mode_chg ? '0 : steps_left;
  assign load_n    = (mode_eff == MODE_BURST && bus.burst_len != '0)
                   ? bus.burst_len - 1'b1 : '0;

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n     = state;
    cnt_n       = phase_cnt;
    div_q_n     = (phase_cnt == '0) ? bus.div : div_q;
    steps_n     = steps_left;
    mode_q_n    = mode_q;
    halt_pend_n = halt_pend;
    enter_high  = 1'b0;
    done_n      = 1'b0;

    unique case (state)
      ST_LOW: begin
        mode_q_n = mode_eff;
        steps_n  = steps_eff;
        if (bus.halt) begin
          state_n = ST_HALT;
          cnt_n   = '0;
          steps_n = '0;
        end else if (mode_eff == MODE_FREE || steps_eff != '0) begin
          if (phase_end) begin
            state_n    = ST_HIGH;
            cnt_n      = '0;
            enter_high = 1'b1;
            if (mode_eff != MODE_FREE) steps_n = steps_eff - 1'b1;
          end else begin
            cnt_n = phase_cnt + 1'b1;
          end
        end else begin
          // Idle between step sequences: hold the counter at phase start
          cnt_n = '0;
          if (step_req) begin
            state_n    = ST_HIGH;
            enter_high = 1'b1;
            steps_n    = load_n;
          end
        end
      end

      ST_HIGH: begin
        if (bus.halt) halt_pend_n = 1'b1;
        if (phase_end) begin
          cnt_n       = '0;
          halt_pend_n = 1'b0;
          if (bus.halt || halt_pend) begin
            state_n = ST_HALT;
            steps_n = '0;
          end else begin
            state_n = ST_LOW;
            done_n  = (mode_q != MODE_FREE) && (steps_left == '0);
          end
        end else begin
          cnt_n = phase_cnt + 1'b1;
        end
      end

      default: begin
        state_n     = ST_HALT;
        cnt_n       = '0;
        steps_n     = '0;
        halt_pend_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_LOW;
      phase_cnt      <= '0;
      div_q          <= '0;
      steps_left     <= '0;
      mode_q         <= MODE_FREE;
      halt_pend      <= 1'b0;
      bus.cpu_clk    <= 1'b0;
      bus.rise_pulse <= 1'b0;
      bus.burst_done <= 1'b0;
      bus.halted     <= 1'b0;
    end else begin
      state          <= state_n;
      phase_cnt      <= cnt_n;
      div_q          <= div_q_n;
      steps_left     <= steps_n;
      mode_q         <= mode_q_n;
      halt_pend      <= halt_pend_n;
      bus.cpu_clk    <= (state_n == ST_HIGH);
      bus.rise_pulse <= enter_high;
      bus.burst_done <= done_n;
      bus.halted     <= (state_n == ST_HALT);
    end
  end

endmodule

// File: tb/tb_clock_controller.sv
// Self-checking bench for clock_controller: table of mode scenarios with a
// scoreboard of expected rise/done cycles, plus hand-written corner sequences.
module tb_clock_controller;
  localparam int DIV_W   = 24;
  localparam int BURST_W = 8;
  localparam int DEB     = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  clock_controller_if #(.DIV_W(DIV_W), .BURST_W(BURST_W)) bus ();

  clock_controller #(
    .DIV_W(DIV_W), .DEBOUNCE_CYCLES(DEB), .BURST_W(BURST_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int high_cnt    = 0;
  int rise_q[$];
  int done_q[$];

  typedef struct {
    logic [1:0] mode;
    int         div;
    int         blen;
    bit         press;
    int         hold;
    int         first;
    int         period;
    int         n_rise;
    int         done_at;
    int         run;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clk cycle; outputs sampled on the falling edge and scored.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (bus.cpu_clk === 1'b1) high_cnt++;
    if (bus.rise_pulse === 1'b1) begin
      if (rise_q.size() == 0) check("unexpected_rise", cyc, -1);
      else                    check("rise_cycle", cyc, rise_q.pop_front());
    end
    if (bus.burst_done === 1'b1) begin
      if (done_q.size() == 0) check("unexpected_done", cyc, -1);
      else                    check("done_cycle", cyc, done_q.pop_front());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    check("reset_outputs",
          {bus.cpu_clk, bus.rise_pulse, bus.burst_done, bus.halted}, 0);
    rst      = 1'b0;
    cyc      = 0;
    high_cnt = 0;
    rise_q.delete();
    done_q.delete();
  endtask

  task automatic end_check(input string name);
    check({name, "_missing_rises"}, rise_q.size(), 0);
    check({name, "_missing_done"}, done_q.size(), 0);
  endtask

  task automatic setup(input logic [1:0] m, input int d, input int bl);
    bus.mode      = m;
    bus.div       = DIV_W'(d);
    bus.burst_len = BURST_W'(bl);
    bus.halt      = 1'b0;
    bus.step_btn  = 1'b0;
    do_reset();
  endtask

  initial begin
    //         mode  div blen press hold first per n  done run
    tbl[0] = '{2'd0, 2,  0,   0,    0,   3,    6,  7, 0,   41};
    tbl[1] = '{2'd0, 0,  0,   0,    0,   1,    2, 10, 0,   20};
    tbl[2] = '{2'd1, 1,  0,   1,    20,  9,    4,  1, 11,  40};
    tbl[3] = '{2'd3, 1,  0,   1,    20,  9,    4,  1, 11,  40};
    tbl[4] = '{2'd2, 1,  5,   1,    10,  9,    4,  5, 27,  50};
    tbl[5] = '{2'd2, 1,  0,   1,    10,  9,    4,  1, 11,  40};
    tbl[6] = '{2'd2, 2,  3,   1,    10,  9,    6,  3, 24,  50};

    bus.mode = 2'd0; bus.div = '0; bus.burst_len = '0;
    bus.halt = 1'b0; bus.step_btn = 1'b0;

    for (int i = 0; i < 7; i++) begin
      setup(tbl[i].mode, tbl[i].div, tbl[i].blen);
      for (int j = 0; j < tbl[i].n_rise; j++)
        rise_q.push_back(tbl[i].first + tbl[i].period * j);
      if (tbl[i].done_at != 0) done_q.push_back(tbl[i].done_at);
      while (cyc < tbl[i].run) begin
        if (tbl[i].press && cyc == 2) bus.step_btn = 1'b1;
        if (tbl[i].press && cyc == 2 + tbl[i].hold) bus.step_btn = 1'b0;
        tick();
      end
      end_check($sformatf("vec%0d", i));
      check($sformatf("vec%0d_high_cycles", i), high_cnt,
            tbl[i].n_rise * (tbl[i].div + 1));
    end

    // Short 1-0-1 glitch never survives the debouncer
    setup(2'd1, 1, 0);
    while (cyc < 30) begin
      if (cyc inside {2, 4}) bus.step_btn = 1'b1;
      if (cyc inside {3, 5}) bus.step_btn = 1'b0;
      tick();
    end
    end_check("glitch");
    check("glitch_high_cycles", high_cnt, 0);

    // Second press during an active burst is dropped, not queued
    setup(2'd2, 2, 3);
    rise_q = '{9, 15, 21};
    done_q = '{24};
    while (cyc < 50) begin
      if (cyc == 2 || cyc == 14) bus.step_btn = 1'b1;
      if (cyc == 12 || cyc == 24) bus.step_btn = 1'b0;
      tick();
    end
    end_check("repress");

    // div change mid-HIGH leaves that phase at full length
    setup(2'd0, 3, 0);
    rise_q = '{4, 9, 11, 13, 15};
    while (cyc < 16) begin
      if (cyc == 5) bus.div = '0;
      tick();
    end
    end_check("div_change");

    // Halt during HIGH: phase completes, then sticky HALT
    setup(2'd0, 3, 0);
    rise_q = '{4};
    while (cyc < 7) begin
      if (cyc == 5) bus.halt = 1'b1;
      tick();
    end
    check("halt_high_full", bus.cpu_clk, 1);
    tick();
    check("halt_cpu_clk_low", bus.cpu_clk, 0);
    check("halt_halted", bus.halted, 1);
    bus.halt = 1'b0;
    while (cyc < 40) begin
      if (cyc == 10) bus.step_btn = 1'b1;
      if (cyc == 20) bus.step_btn = 1'b0;
      tick();
    end
    check("halt_sticky", bus.halted, 1);
    check("halt_sticky_clk", bus.cpu_clk, 0);
    end_check("halt_high");
    do_reset();

    // Halt during LOW enters HALT on the next cycle
    setup(2'd0, 3, 0);
    bus.halt = 1'b1;
    tick();
    tick();
    check("halt_low_halted", bus.halted, 1);
    bus.halt = 1'b0;
    while (cyc < 20) tick();
    end_check("halt_low");

    // Reset after the third rise of a 10-long burst
    setup(2'd2, 1, 10);
    rise_q = '{9, 13, 17};
    while (cyc < 17) begin
      if (cyc == 2)  bus.step_btn = 1'b1;
      if (cyc == 12) bus.step_btn = 1'b0;
      tick();
    end
    end_check("burst_pre_reset");
    do_reset();
    while (cyc < 40) tick();
    end_check("burst_post_reset");
    check("burst_post_reset_high", high_cnt, 0);

    // Switching to free-run during a burst LOW phase: no burst_done
    setup(2'd2, 1, 5);
    rise_q = '{9, 13, 17, 21, 25, 29};
    while (cyc < 30) begin
      if (cyc == 2)  bus.step_btn = 1'b1;
      if (cyc == 11) bus.mode = 2'd0;
      if (cyc == 12) bus.step_btn = 1'b0;
      tick();
    end
    end_check("mode_switch");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
